// File: rtl/vcore_pkg.sv
// Shared vector-core types and default geometry, common to the VRF and its write-back sequencer.
package vcore_pkg;

  localparam int VC_DATA_WIDTH = 32;
  localparam int VC_REG_NUM    = 32;
  localparam int VC_LANES      = 4;
  localparam int VC_ADDR_B     = $clog2(VC_REG_NUM);
  localparam int VC_ELEM_B     = $clog2(VC_LANES);

  typedef enum logic {
    WB_IDLE  = 1'b0,
    WB_WRITE = 1'b1
  } wb_state_t;

  // Element i of data sits at bits [i*VC_DATA_WIDTH +: VC_DATA_WIDTH] when flattened.
  typedef struct packed {
    logic [VC_ADDR_B-1:0]                    addr;
    logic [VC_LANES-1:0][VC_DATA_WIDTH-1:0]  data;
    logic [VC_LANES-1:0]                     mask;
  } wb_entry_t;

endpackage

// File: rtl/vrf_wb_seq_if.sv
// Result-vector handshake and VRF write-port bundle for the write-back sequencer.
interface vrf_wb_seq_if
  import vcore_pkg::*;
#(
  parameter int DATA_WIDTH = VC_DATA_WIDTH,
  parameter int REG_NUM    = VC_REG_NUM,
  parameter int LANES      = VC_LANES
);
  localparam int ADDR_B = $clog2(REG_NUM);
  localparam int ELEM_B = $clog2(LANES);

  logic                    res_valid;
  logic                    res_ready;
  logic [ADDR_B-1:0]       res_addr;
  logic [LANES*DATA_WIDTH-1:0] res_data;
  logic [LANES-1:0]        res_mask;

  logic                    wr_req;
  logic                    wr_en;
  logic                    wr_ready;
  logic [ELEM_B-1:0]       wr_elem_cnt;
  logic [ADDR_B-1:0]       wr_addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [REG_NUM-1:0]      pend_mask;
  logic                    wb_done;

  modport slave (
    input  res_valid, res_addr, res_data, res_mask,
    output res_ready, wr_req, wr_en, wr_ready, wr_elem_cnt, wr_addr, wdata,
           pend_mask, wb_done
  );

  modport master (
    output res_valid, res_addr, res_data, res_mask,
    input  res_ready, wr_req, wr_en, wr_ready, wr_elem_cnt, wr_addr, wdata,
           pend_mask, wb_done
  );

endinterface

// File: rtl/vrf_wb_fifo.sv
// DEPTH-entry result FIFO of wb_entry_t; exposes per-slot valid/addr so the owner can build a pending mask.
module vrf_wb_fifo
  import vcore_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                            clk_i,
  input  logic                            resetn_i,
  input  logic                            push,
  input  wb_entry_t                       din,
  input  logic                            pop,
  output wb_entry_t                       head,
  output logic                            full,
  output logic                            empty,
  output logic [DEPTH-1:0]                ent_vld,
  output logic [DEPTH-1:0][VC_ADDR_B-1:0] ent_addr
);

  localparam int PTR_B = $clog2(DEPTH);

  wb_entry_t         mem [DEPTH];
  logic [PTR_B-1:0]  rd_ptr;
  logic [PTR_B-1:0]  wr_ptr;
  logic [PTR_B:0]    count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (PTR_B+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage is cleared on reset so the stale head (address/data) reads as zero.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A slot is live when its distance from the read pointer is below the fill level.
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [PTR_B-1:0] off;
    assign off         = PTR_B'(g) - rd_ptr;
    assign ent_vld[g]  = ({1'b0, off} < count);
    assign ent_addr[g] = mem[g].addr;
  end

endmodule

// File: rtl/vrf_wb_seq.sv
// Write-back sequencer: buffers result vectors and serialises them onto the VRF write port.
// Optional VRF_WB_MASK_EN: per-element wr_en from the stored mask instead of always writing.
module vrf_wb_seq
  import vcore_pkg::*;
#(
  parameter int DATA_WIDTH = VC_DATA_WIDTH,
  parameter int REG_NUM    = VC_REG_NUM,
  parameter int LANES      = VC_LANES,
  parameter int DEPTH      = 2
) (
  input  logic          clk_i,
  input  logic          resetn_i,
  vrf_wb_seq_if.slave   bus
);

  localparam int ELEM_B = $clog2(LANES);

  wb_entry_t                       din;
  wb_entry_t                       head;
  logic                            push;
  logic                            pop;
  logic                            full;
  logic                            empty;
  logic [DEPTH-1:0]                ent_vld;
  logic [DEPTH-1:0][VC_ADDR_B-1:0] ent_addr;

  wb_state_t            state, state_n;
  logic [ELEM_B-1:0]    cnt, cnt_n;
  logic [DATA_WIDTH-1:0] elem;
  logic                 elem_en;
  logic [REG_NUM-1:0]   pend;

  // No pass-through: a pop in the same cycle does not open a full FIFO.
  assign bus.res_ready = !full;
  assign push          = bus.res_valid && !full;
  assign din           = {bus.res_addr, bus.res_data, bus.res_mask};

  vrf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .push     (push),
    .din      (din),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .ent_vld  (ent_vld),
    .ent_addr (ent_addr)
  );

  assign elem        = head.data[cnt];
  assign bus.wr_addr = head.addr;

`ifdef VRF_WB_MASK_EN
  assign elem_en = head.mask[cnt];
`else
  assign elem_en = 1'b1;
`endif

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state <= WB_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // IDLE always occupies one cycle between vectors because the VRF only samples wr_req when idle.
  always_comb begin
    state_n         = state;
    cnt_n           = cnt;
    pop             = 1'b0;
    bus.wr_req      = 1'b0;
    bus.wr_en       = 1'b0;
    bus.wr_ready    = 1'b0;
    bus.wb_done     = 1'b0;
    bus.wr_elem_cnt = '0;
    bus.wdata       = '0;
    case (state)
      WB_IDLE: begin
        bus.wr_req = !empty;
        if (!empty) begin
          state_n = WB_WRITE;
          cnt_n   = '0;
        end
      end
      WB_WRITE: begin
        bus.wr_elem_cnt = cnt;
        bus.wdata       = elem;
        bus.wr_en       = elem_en;
        if (cnt == ELEM_B'(LANES-1)) begin
          bus.wr_ready = 1'b1;
          bus.wb_done  = 1'b1;
          pop          = 1'b1;
          cnt_n        = '0;
          state_n      = WB_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = WB_IDLE;
    endcase
  end

  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i]) pend[ent_addr[i]] = 1'b1;
    end
  end

  assign bus.pend_mask = pend;

endmodule

// File: tb/tb_vrf_wb_seq.sv
// Self-checking bench for vrf_wb_seq: directed table/sequences plus a randomized queue-based reference model.
module tb_vrf_wb_seq;

  localparam int DW = 32, RN = 32, LN = 4, DEPTH = 2, AB = 5, EB = 2;
`ifdef VRF_WB_MASK_EN
  localparam bit MASK_ON = 1'b1;
`else
  localparam bit MASK_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  vrf_wb_seq_if #(.DATA_WIDTH(DW), .REG_NUM(RN), .LANES(LN)) bus ();

  vrf_wb_seq #(.DATA_WIDTH(DW), .REG_NUM(RN), .LANES(LN), .DEPTH(DEPTH)) dut (
    .clk_i    (clk),
    .resetn_i (rstn),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.res_valid = 1'b0;
    bus.res_addr  = '0;
    bus.res_data  = '0;
    bus.res_mask  = '0;
  endtask

  task automatic set_in(input logic [AB-1:0] a, input logic [LN*DW-1:0] d, input logic [LN-1:0] m);
    bus.res_valid = 1'b1;
    bus.res_addr  = a;
    bus.res_data  = d;
    bus.res_mask  = m;
  endtask

  task automatic do_reset();
    idle_in();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  function automatic logic exp_en(input logic [LN-1:0] m, input int i);
    return MASK_ON ? m[i] : 1'b1;
  endfunction

  typedef struct {
    logic          vld;
    logic [AB-1:0] a;
    logic [LN*DW-1:0] d;
    logic [LN-1:0] m;
    logic          req;
    logic          en;
    logic          last;
    logic [EB-1:0] ecnt;
    logic [DW-1:0] wd;
    logic [AB-1:0] wa;
    logic [RN-1:0] pend;
    logic          rdy;
    logic          wr;
  } vec_t;

  typedef struct {
    logic [AB-1:0]    a;
    logic [LN*DW-1:0] d;
    logic [LN-1:0]    m;
  } ent_t;

  vec_t tbl[6];
  ent_t q[$];

  initial begin
    logic [LN*DW-1:0] d0;
    logic [LN-1:0]    m0;
    logic             rq[12], en[12], dn[12];
    logic [AB-1:0]    ad[12];
    logic [RN-1:0]    pm[13];
    logic             rd[21];
    int               acc[3];
    int               idx;
    logic [AB-1:0]    seen_a[$];
    logic [DW-1:0]    seen_d[$];
    int               phase;

    idle_in();
    do_reset();

    // Reset state
    chk("rst.req",   bus.wr_req, 0);
    chk("rst.en",    bus.wr_en, 0);
    chk("rst.ready", bus.wr_ready, 0);
    chk("rst.done",  bus.wb_done, 0);
    chk("rst.cnt",   bus.wr_elem_cnt, 0);
    chk("rst.wdata", bus.wdata, 0);
    chk("rst.addr",  bus.wr_addr, 0);
    chk("rst.pend",  bus.pend_mask, 0);
    chk("rst.res_ready", bus.res_ready, 1);

    // Single vector, table-driven
    d0 = 128'h00000044_00000033_00000022_00000011;
    m0 = 4'b0101;
    tbl[0] = '{vld:1, a:5, d:d0, m:m0, req:1, en:0, last:0, ecnt:0, wd:0, wa:5,
               pend:32'h20, rdy:1, wr:0};
    for (int i = 0; i < 4; i++)
      tbl[i+1] = '{vld:0, a:0, d:0, m:0, req:0, en:exp_en(m0, i), last:(i == 3),
                   ecnt:EB'(i), wd:d0[i*DW +: DW], wa:5, pend:32'h20, rdy:1, wr:1};
    tbl[5] = '{vld:0, a:0, d:0, m:0, req:0, en:0, last:0, ecnt:0, wd:0, wa:0,
               pend:0, rdy:1, wr:0};
    for (int r = 0; r < 6; r++) begin
      if (tbl[r].vld) set_in(tbl[r].a, tbl[r].d, tbl[r].m);
      else            idle_in();
      step();
      chk($sformatf("tbl%0d.req", r),  bus.wr_req, tbl[r].req);
      chk($sformatf("tbl%0d.en", r),   bus.wr_en, tbl[r].en);
      chk($sformatf("tbl%0d.ready", r), bus.wr_ready, tbl[r].last);
      chk($sformatf("tbl%0d.done", r), bus.wb_done, tbl[r].last);
      chk($sformatf("tbl%0d.cnt", r),  bus.wr_elem_cnt, tbl[r].ecnt);
      chk($sformatf("tbl%0d.pend", r), bus.pend_mask, tbl[r].pend);
      chk($sformatf("tbl%0d.res_ready", r), bus.res_ready, tbl[r].rdy);
      if (tbl[r].req || tbl[r].wr) chk($sformatf("tbl%0d.addr", r), bus.wr_addr, tbl[r].wa);
      if (tbl[r].wr) chk($sformatf("tbl%0d.wdata", r), bus.wdata, tbl[r].wd);
    end

    // Back-to-back: req, 4 writes reg1, req, 4 writes reg2
    do_reset();
    set_in(1, 128'h1, 4'hF);
    step();
    rq[1] = bus.wr_req; en[1] = bus.wr_en; dn[1] = bus.wb_done; ad[1] = bus.wr_addr;
    set_in(2, 128'h2, 4'hF);
    step();
    rq[2] = bus.wr_req; en[2] = bus.wr_en; dn[2] = bus.wb_done; ad[2] = bus.wr_addr;
    idle_in();
    for (int c = 3; c < 12; c++) begin
      step();
      rq[c] = bus.wr_req; en[c] = bus.wr_en; dn[c] = bus.wb_done; ad[c] = bus.wr_addr;
    end
    for (int c = 1; c < 12; c++) begin
      chk($sformatf("b2b.req@%0d", c),  rq[c], (c == 1 || c == 6));
      chk($sformatf("b2b.en@%0d", c),   en[c], ((c >= 2 && c <= 5) || (c >= 7 && c <= 10)));
      chk($sformatf("b2b.done@%0d", c), dn[c], (c == 5 || c == 10));
      if (c <= 10) chk($sformatf("b2b.addr@%0d", c), ad[c], (c <= 5) ? 1 : 2);
    end

    // Backpressure: three vectors with valid held
    do_reset();
    idx = 0;
    for (int c = 0; c < 21; c++) begin
      if (idx < 3) set_in(AB'(10 + idx), {96'h0, 32'hA0 + 32'(idx)}, 4'hF);
      else         idle_in();
      rd[c] = bus.res_ready;
      if (idx < 3 && rd[c]) begin
        acc[idx] = c;
        idx++;
      end
      step();
      if (bus.wr_req) seen_a.push_back(bus.wr_addr);
      if (bus.wr_en && bus.wr_elem_cnt == 0) seen_d.push_back(bus.wdata);
    end
    chk("bp.acc0", acc[0], 0);
    chk("bp.acc1", acc[1], 1);
    chk("bp.acc2", acc[2], 6);
    chk("bp.ready_full", rd[2], 0);
    chk("bp.ready_pop_cycle", rd[5], 0);
    chk("bp.nreq", seen_a.size(), 3);
    chk("bp.ndata", seen_d.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < seen_a.size()) chk($sformatf("bp.order_addr%0d", i), seen_a[i], 10 + i);
      if (i < seen_d.size()) chk($sformatf("bp.order_data%0d", i), seen_d[i], 32'hA0 + i);
    end

    // Reset mid-write with one vector queued
    do_reset();
    set_in(3, 128'h33, 4'hF);
    step();
    set_in(9, 128'h99, 4'hF);
    step();
    idle_in();
    step();
    chk("mid.cnt_before", bus.wr_elem_cnt, 1);
    rstn = 1'b0;
    #1;
    chk("mid.req",   bus.wr_req, 0);
    chk("mid.en",    bus.wr_en, 0);
    chk("mid.ready", bus.wr_ready, 0);
    chk("mid.done",  bus.wb_done, 0);
    chk("mid.cnt",   bus.wr_elem_cnt, 0);
    chk("mid.wdata", bus.wdata, 0);
    chk("mid.addr",  bus.wr_addr, 0);
    chk("mid.pend",  bus.pend_mask, 0);
    chk("mid.res_ready", bus.res_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      chk($sformatf("mid.post_req@%0d", c), bus.wr_req, 0);
      chk($sformatf("mid.post_en@%0d", c),  bus.wr_en, 0);
      chk($sformatf("mid.post_pend@%0d", c), bus.pend_mask, 0);
    end

    // Duplicate destination register 7
    do_reset();
    set_in(7, 128'h7, 4'hF);
    step();
    pm[1] = bus.pend_mask;
    set_in(7, 128'h77, 4'hF);
    step();
    pm[2] = bus.pend_mask;
    idle_in();
    for (int c = 3; c < 13; c++) begin
      step();
      pm[c] = bus.pend_mask;
    end
    for (int c = 1; c < 13; c++)
      chk($sformatf("dup.pend@%0d", c), pm[c], (c <= 10) ? 32'h80 : 32'h0);

    // Randomized run against the queue-level reference model
    do_reset();
    q.delete();
    phase = -1;
    for (int cyc = 0; cyc < 800; cyc++) begin
      logic          rdy_e;
      logic [RN-1:0] pend_e;
      logic [LN*DW-1:0] dr;
      logic          push_e, pop_e;
      rdy_e  = (q.size() < DEPTH);
      pend_e = '0;
      foreach (q[i]) pend_e[q[i].a] = 1'b1;
      chk($sformatf("rnd%0d.res_ready", cyc), bus.res_ready, rdy_e);
      chk($sformatf("rnd%0d.pend", cyc), bus.pend_mask, pend_e);
      if (phase < 0) begin
        chk($sformatf("rnd%0d.req", cyc), bus.wr_req, q.size() > 0);
        chk($sformatf("rnd%0d.en", cyc), bus.wr_en, 0);
        chk($sformatf("rnd%0d.done", cyc), bus.wb_done, 0);
        chk($sformatf("rnd%0d.ready", cyc), bus.wr_ready, 0);
        chk($sformatf("rnd%0d.cnt", cyc), bus.wr_elem_cnt, 0);
        if (q.size() > 0) chk($sformatf("rnd%0d.addr", cyc), bus.wr_addr, q[0].a);
      end else begin
        chk($sformatf("rnd%0d.req", cyc), bus.wr_req, 0);
        chk($sformatf("rnd%0d.en", cyc), bus.wr_en, exp_en(q[0].m, phase));
        chk($sformatf("rnd%0d.done", cyc), bus.wb_done, phase == LN-1);
        chk($sformatf("rnd%0d.ready", cyc), bus.wr_ready, phase == LN-1);
        chk($sformatf("rnd%0d.cnt", cyc), bus.wr_elem_cnt, phase);
        chk($sformatf("rnd%0d.addr", cyc), bus.wr_addr, q[0].a);
        chk($sformatf("rnd%0d.wdata", cyc), bus.wdata, q[0].d[phase*DW +: DW]);
      end
      // Upstream holds a stalled request; otherwise offer a new one at random
      if (!(bus.res_valid && !rdy_e)) begin
        if ($urandom_range(0, 99) < 55) begin
          for (int k = 0; k < LN; k++) dr[k*DW +: DW] = $urandom;
          set_in(($urandom_range(0, 3) == 0) ? AB'($urandom) : AB'($urandom_range(0, 7)),
                 dr, LN'($urandom));
        end else begin
          idle_in();
        end
      end
      push_e = bus.res_valid && rdy_e;
      pop_e  = (phase == LN-1);
      if (phase < 0)            phase = (q.size() > 0) ? 0 : -1;
      else if (phase == LN-1)   phase = -1;
      else                      phase++;
      if (pop_e) void'(q.pop_front());
      if (push_e) q.push_back('{a:bus.res_addr, d:bus.res_data, m:bus.res_mask});
      step();
    end
    idle_in();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
